// File: rtl/conv_8x32_ctrl.sv
// conv_8x32_ctrl
// Sequencer for the 8x32 convolution coprocessor: y[n] = sum_k h[k]*x[n-k].
// For every output index n it clears the MAC accumulator, steps through all
// kernel taps k while driving the x/h read addresses, then writes the
// accumulator to y memory at address n. Out-of-range taps are suppressed
// with mac_en=0 and an all-zero operand mask.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, only honoured while idle
//   abort     in   cancel the current run (returns to idle on next edge)
//   busy      out  high from the cycle after an accepted start until DONE exits
//   done      out  one-cycle pulse when a run completes (never on abort)
//   x_addr    out  x register-file read address
//   h_addr    out  h register-file read address
//   tap_mask  out  all-ones for a valid tap, else zero; ANDed onto operands
//   acc_clr   out  clear the MAC accumulator
//   mac_en    out  accumulate the gated product this cycle
//   y_we      out  write the accumulator to y memory
//   y_addr    out  y write address (= n)
//
// Every output is decoded from registered state/counters only, so there is
// no combinational path from start/abort to any output.

`timescale 1ns/1ps

module conv_8x32_ctrl #(
  parameter int X_LEN = 32,
  parameter int H_LEN = 8,
  parameter int XA_W  = $clog2(X_LEN),
  parameter int HA_W  = $clog2(H_LEN),
  parameter int YA_W  = $clog2(X_LEN + H_LEN - 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [XA_W-1:0] x_addr,
  output logic [HA_W-1:0] h_addr,
  output logic [7:0]      tap_mask,
  output logic            acc_clr,
  output logic            mac_en,
  output logic            y_we,
  output logic [YA_W-1:0] y_addr
);

  localparam int Y_LEN = X_LEN + H_LEN - 1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    WRITE,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [YA_W-1:0] n_reg, n_next;
  logic [HA_W-1:0] k_reg, k_next;

  // n-k is formed one bit wider than n so that k>n shows up as a set MSB
  // instead of wrapping into what would look like a legal x index.
  logic [YA_W:0]   diff;
  logic            tap_ok;
  logic            tap_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    k_next     = k_reg;
    if (abort && (state_reg != IDLE)) begin
      // abort beats every other transition, DONE included
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // start together with abort is refused
          if (start && !abort) begin
            state_next = CLR;
            n_next     = '0;
          end
        end
        CLR: begin
          k_next     = '0;
          state_next = MAC;
        end
        MAC: begin
          if (k_reg == HA_W'(H_LEN - 1)) begin
            state_next = WRITE;
          end else begin
            k_next = k_reg + HA_W'(1);
          end
        end
        WRITE: begin
          if (n_reg == YA_W'(Y_LEN - 1)) begin
            state_next = DONE;
          end else begin
            n_next     = n_reg + YA_W'(1);
            state_next = CLR;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign diff      = {1'b0, n_reg} - (YA_W + 1)'(k_reg);
  assign tap_ok    = !diff[YA_W] && (diff < (YA_W + 1)'(X_LEN));
  assign tap_valid = (state_reg == MAC) && tap_ok;

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign acc_clr = (state_reg == CLR);
  assign mac_en  = tap_valid;
  assign y_we    = (state_reg == WRITE);
  assign y_addr  = (state_reg == WRITE) ? n_reg : '0;
  assign h_addr  = (state_reg == MAC) ? k_reg : '0;
  assign x_addr  = (state_reg == MAC) ? diff[XA_W-1:0] : '0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign tap_mask[gi] = tap_valid;
  end

endmodule

// File: tb/tb_conv_8x32_ctrl.sv
// Testbench for conv_8x32_ctrl.
// A bench-side MAC and x/h/y memories are driven by the DUT's strobes and
// addresses. When a run is issued, the expected y writes (convolution
// computed directly from the x/h arrays) and the done pulse, each with its
// expected cycle, are queued; a monitor pops and compares on every y_we/done.

`timescale 1ns/1ps

module tb_conv_8x32_ctrl;

  localparam int X_LEN = 32;
  localparam int H_LEN = 8;
  localparam int Y_LEN = 39;
  localparam int XA_W  = 5;
  localparam int HA_W  = 3;
  localparam int YA_W  = 6;
  localparam int RUN   = 391;   // cycles from start to done

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic            busy;
  logic            done;
  logic [XA_W-1:0] x_addr;
  logic [HA_W-1:0] h_addr;
  logic [7:0]      tap_mask;
  logic            acc_clr;
  logic            mac_en;
  logic            y_we;
  logic [YA_W-1:0] y_addr;

  always #5 clk = ~clk;

  conv_8x32_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .x_addr   (x_addr),
    .h_addr   (h_addr),
    .tap_mask (tap_mask),
    .acc_clr  (acc_clr),
    .mac_en   (mac_en),
    .y_we     (y_we),
    .y_addr   (y_addr)
  );

  typedef struct {
    bit     is_done;
    int     addr;
    longint val;
    int     cyc;
  } ev_t;

  ev_t         sbq[$];
  logic [7:0]  xm[X_LEN];
  logic [7:0]  hm[H_LEN];
  longint      ym[Y_LEN];
  logic [31:0] acc;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          n_mac = 0;
  int          n_clr = 0;
  int          n_busy = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // bench datapath: gated MAC driven by the sequencer
  always @(posedge clk) begin
    if (acc_clr) acc <= 32'd0;
    else if (mac_en) acc <= acc + ((xm[x_addr] & tap_mask) * (hm[h_addr] & tap_mask));
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (busy)    n_busy++;
      if (mac_en)  n_mac++;
      if (acc_clr) n_clr++;
      chk("tap_mask", tap_mask, mac_en ? 255 : 0);
      if (!busy) chk("idle_quiet", {acc_clr, mac_en, y_we, done}, 0);
      if (y_we || done) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_event: got y_we=%0b done=%0b, expected none (cycle %0d)",
                   y_we, done, cyc);
        end else begin
          e = sbq.pop_front();
          chk("ev_kind", done, e.is_done);
          chk("ev_cycle", cyc, e.cyc);
          if (y_we) begin
            chk("y_addr", y_addr, e.addr);
            chk("y_value", acc, e.val);
            ym[y_addr] = acc;
          end
        end
      end
    end
  end

  function automatic longint ref_y(input int n);
    longint s = 0;
    for (int k = 0; k < H_LEN; k++) begin
      if (n - k >= 0 && n - k < X_LEN) s += longint'(xm[n - k]) * longint'(hm[k]);
    end
    return s;
  endfunction

  task automatic load(input bit golden);
    for (int i = 0; i < X_LEN; i++) xm[i] = golden ? 8'(i + 1) : 8'($urandom_range(0, 255));
    for (int i = 0; i < H_LEN; i++) hm[i] = golden ? 8'd1 : 8'($urandom_range(0, 255));
  endtask

  // v = cyc value during the cycle in which start is driven
  task automatic push_run(input int v, input int n_writes, input bit with_done);
    ev_t e;
    for (int n = 0; n < n_writes; n++) begin
      e.is_done = 1'b0; e.addr = n; e.val = ref_y(n); e.cyc = v + 10 + 10 * n;
      sbq.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1; e.addr = 0; e.val = 0; e.cyc = v + RUN;
      sbq.push_back(e);
    end
  endtask

  task automatic run_full(input bit golden);
    int v, mac0, clr0, busy0;
    load(golden);
    @(posedge clk); #1;
    v = cyc; mac0 = n_mac; clr0 = n_clr; busy0 = n_busy;
    push_run(v, Y_LEN, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RUN) @(posedge clk);
    #1;
    chk("busy_after_run", busy, 0);
    chk("mac_en_count", n_mac - mac0, 256);
    chk("acc_clr_count", n_clr - clr0, 39);
    chk("busy_count", n_busy - busy0, 391);
    chk("sb_drained", sbq.size(), 0);
    $display("run full golden=%0b start_cyc=%0d", golden, v);
  endtask

  task automatic run_cut(input int a, input int j, input bit use_reset);
    int v;
    load(1'b0);
    @(posedge clk); #1;
    v = cyc;
    push_run(v, a, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1 + 10 * a + j) @(posedge clk);
    #1;
    if (!use_reset) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {done, y_we, mac_en, acc_clr}, 0);
    end else begin
      rst_n = 1'b0;
      #1;
      chk("rst_ctrl", {busy, done, acc_clr, mac_en, y_we}, 0);
      chk("rst_addr", {x_addr, h_addr, y_addr, tap_mask}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("cut_idle", busy, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("run cut reset=%0b n=%0d tap=%0d start_cyc=%0d", use_reset, a, j, v);
  endtask

  task automatic run_held_start();
    int v;
    load(1'b0);
    @(posedge clk); #1;
    v = cyc;
    push_run(v, Y_LEN, 1'b1);
    push_run(v + RUN + 1, Y_LEN, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    repeat (RUN) @(posedge clk);
    #1;
    chk("held_idle_gap", busy, 0);
    @(posedge clk); #1;
    chk("held_reaccept", busy, 1);
    start = 1'b0;
    repeat (RUN) @(posedge clk);
    #1;
    chk("held_end_idle", busy, 0);
    chk("sb_drained", sbq.size(), 0);
    $display("run held-start start_cyc=%0d", v);
  endtask

  task automatic start_with_abort();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_refused", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_idle", busy, 0);
    $display("start+abort in idle refused");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    for (int i = 0; i < Y_LEN; i++) ym[i] = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, acc_clr, mac_en, y_we}, 0);
    chk("reset_addr", {x_addr, h_addr, y_addr, tap_mask}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_full(1'b1);
    chk("golden_y0", ym[0], 1);
    chk("golden_y7", ym[7], 36);
    chk("golden_y31", ym[31], 228);
    chk("golden_y38", ym[38], 32);

    run_full(1'b0);
    run_cut(5, $urandom_range(0, 7), 1'b0);
    run_full(1'b0);
    start_with_abort();
    run_cut($urandom_range(1, 37), $urandom_range(0, 7), 1'b1);
    run_full(1'b0);
    run_held_start();
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 1) == 1) run_cut($urandom_range(0, 38), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else run_full(1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
